alu: RTL and testbench
======================

Name: alu

Overview:
- RV32 integer ALU for the cotm32 execute stage.
- Computes one of the RV32I arithmetic, logic, compare and shift results from two XLEN operands, selected by a 4-bit opcode.
- Result is purely combinational on `o`, with a zero-latency path for the datapath.
- A clocked copy of the result and a zero flag is also provided for pipelined consumers and debug.

Parameters:
- XLEN, 32 (from cotm32_pkg, not a module parameter): datapath width.

Ports:
- i_clk  in  1  clock; all registered outputs update on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_a    in  XLEN  operand A (rs1 / PC)
- i_b    in  XLEN  operand B (rs2 / immediate / shift amount)
- i_op   in  alu_op_t (4)  operation select
- o      out  XLEN  combinational result
- o_zero  out  1  combinational, 1 when o == 0
- o_q    out  XLEN  registered copy of o
- o_zero_q  out  1  registered copy of o_zero

Behaviour:
- alu_op_t encoding is {funct7[5], funct3}:
  - ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101, PASS_B=1111.
- Operations:
  - ADD, SUB: modulo 2^XLEN; carry and borrow are discarded.
  - SLT: signed two's-complement compare; o = {31'b0, a<b}.
  - SLTU: unsigned compare; o = {31'b0, a<b}.
  - SLL, SRL, SRA: shift amount = i_b[4:0] only; upper bits of i_b are ignored. SRA replicates a[31]. A shift of 0 returns a unchanged.
  - PASS_B: o = i_b (used for LUI).
- Any unlisted opcode (including MUL codes when the optional feature is out) gives o = 0. No X propagation.
- o and o_zero have zero latency and settle within the same delta as the input changes. No clock is required for them.
- o_q and o_zero_q capture o and o_zero on every rising i_clk edge; latency is 1 cycle.
- i_rst high at a rising edge: o_q = 0 and o_zero_q = 1 (consistent with a zero result). Reset dominates capture on that edge.
- Reset has no effect on the combinational outputs.

Optional Feature:
- Macro: COTM32_ALU_MUL_EN.
- Defined: adds MUL=1001 (low 32 bits of a*b), MULH=1010 (signed×signed, high 32), MULHSU=1011 (signed a × unsigned b, high 32) and MULHU=1100 (unsigned×unsigned, high 32). All are combinational like the other ops.
- Undefined: those codes fall into the unlisted-opcode rule (o = 0), and no multiplier logic is synthesized.

Decomposition:
- cotm32_pkg holds XLEN and the typedef enum logic [3:0] alu_op_t with all codes, including the MUL codes, which are always declared.
- One natural sub-module: alu_shifter, a barrel shifter taking {a, shamt[4:0], dir, arith}.
- Comparators, adder and multiplier stay inline.

Test Plan:
- ADD 1+2 -> o=3; SUB 8-3 -> o=5; ADD 0xFFFFFFFF+1 -> o=0 and o_zero=1.
- Logic ops on a=0x68, b=0x55: OR -> 0x7D, AND -> 0x40, XOR -> 0x3D.
- SLT a=-30, b=25 -> 1; SLTU same operands -> 0; SLT with a=b -> 0.
- Shifts:
  - SLL 30<<2 -> 120.
  - SRL 0xFFFFFFFF>>8 -> 0x00FFFFFF.
  - SRA -60>>2 -> -15 (0xFFFFFFF1).
  - SLL with b=0x21 -> shift by 1.
- Registered path: apply ADD 1+2 and clock -> o_q=3 and o_zero_q=0 one edge later. Assert i_rst for one edge -> o_q=0 and o_zero_q=1 while o still reads 3.
- Optional feature:
  - With COTM32_ALU_MUL_EN: MUL 7×-3 -> 0xFFFFFFEB; MULHU 0xFFFFFFFF×2 -> 1.
  - Without it: opcode 1001 -> o=0.

Source files
------------

// File: rtl/cotm32_pkg.sv
// ---------------------------------------------------------------------------
// cotm32_pkg -- shared definitions for the cotm32 execute stage.
//
// Contents:
//   XLEN      datapath width (32)
//   SHAMT_W   width of a shift amount (log2 XLEN)
//   alu_op_t  ALU operation select, encoded as {funct7[5], funct3}
//
// The multiply codes are always declared so that decode logic has stable
// names. Whether the ALU implements them depends on COTM32_ALU_MUL_EN.
// ---------------------------------------------------------------------------
package cotm32_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_MUL    = 4'b1001,
    ALU_MULH   = 4'b1010,
    ALU_MULHSU = 4'b1011,
    ALU_MULHU  = 4'b1100,
    ALU_SRA    = 4'b1101,
    ALU_PASS_B = 4'b1111
  } alu_op_t;

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter -- logarithmic barrel shifter for the cotm32 ALU.
//
// Ports:
//   a      in  XLEN     value to shift
//   shamt  in  SHAMT_W  shift distance
//   dir    in  1        0 = shift left, 1 = shift right
//   arith  in  1        on a right shift, fill with a[XLEN-1] instead of 0
//   y      out XLEN     shifted result
//
// Only a right-shifting network is built. A left shift is done by
// bit-reversing the operand, shifting right, and reversing back, so the
// same SHAMT_W mux stages serve SLL, SRL and SRA.
// ---------------------------------------------------------------------------
module alu_shifter
  import cotm32_pkg::*;
(
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               arith,
  output logic [XLEN-1:0]    y
);

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  logic            fill;
  logic [XLEN-1:0] stage [SHAMT_W+1];

  // Sign fill only makes sense shifting right; a left shift always brings in zeros.
  assign fill     = arith & dir & a[XLEN-1];
  assign stage[0] = dir ? a : bit_reverse(a);

  // Stage s shifts right by 2**s when shamt[s] is set.
  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int N = 1 << s;
    assign stage[s+1] = shamt[s] ? {{N{fill}}, stage[s][XLEN-1:N]} : stage[s];
  end

  assign y = dir ? stage[SHAMT_W] : bit_reverse(stage[SHAMT_W]);

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- RV32 integer ALU for the cotm32 execute stage.
//
// Ports:
//   i_clk     in  1         clock for the registered outputs
//   i_rst     in  1         synchronous, active-high reset (registered outputs only)
//   i_a       in  XLEN      operand A (rs1 / PC)
//   i_b       in  XLEN      operand B (rs2 / immediate / shift amount)
//   i_op      in  alu_op_t  operation select
//   o         out XLEN      combinational result
//   o_zero    out 1         combinational, 1 when o == 0
//   o_q       out XLEN      o registered on i_clk
//   o_zero_q  out 1         o_zero registered on i_clk
//
// Build option:
//   COTM32_ALU_MUL_EN  when defined, adds MUL/MULH/MULHSU/MULHU. When not
//                      defined those codes return 0 and no multiplier exists.
//
// Unlisted opcodes always produce 0 so the result never carries X.
// ---------------------------------------------------------------------------
module alu
  import cotm32_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_t         i_op,
  output logic [XLEN-1:0] o,
  output logic            o_zero,
  output logic [XLEN-1:0] o_q,
  output logic            o_zero_q
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] shift_y;

  assign sum         = i_a + i_b;
  assign diff        = i_a - i_b;
  assign lt_signed   = $signed(i_a) < $signed(i_b);
  assign lt_unsigned = i_a < i_b;

  // Opcode bit 2 separates SLL (0001) from SRL/SRA (x101), and bit 3
  // separates SRA from SRL, so the shifter controls come straight from i_op.
  alu_shifter u_shifter (
    .a     (i_a),
    .shamt (i_b[SHAMT_W-1:0]),
    .dir   (i_op[2]),
    .arith (i_op[3]),
    .y     (shift_y)
  );

`ifdef COTM32_ALU_MUL_EN
  // One 2*XLEN multiplier serves all four ops. Each operand is sign- or
  // zero-extended to 2*XLEN, after which the truncated product equals the
  // exact product for every signedness combination.
  logic                sign_a;
  logic                sign_b;
  logic [2*XLEN-1:0]   mul_a;
  logic [2*XLEN-1:0]   mul_b;
  logic [2*XLEN-1:0]   product;

  assign sign_a  = ((i_op == ALU_MULH) || (i_op == ALU_MULHSU)) & i_a[XLEN-1];
  assign sign_b  = (i_op == ALU_MULH) & i_b[XLEN-1];
  assign mul_a   = {{XLEN{sign_a}}, i_a};
  assign mul_b   = {{XLEN{sign_b}}, i_b};
  assign product = mul_a * mul_b;
`endif

  always_comb begin
    // NOTE: o gets a default before the case so every path assigns it; this
    // prevents a latch and gives unlisted opcodes their required zero result.
    o = '0;
    case (i_op)
      ALU_ADD:    o = sum;
      ALU_SUB:    o = diff;
      ALU_SLT:    o = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:   o = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:    o = i_a ^ i_b;
      ALU_OR:     o = i_a | i_b;
      ALU_AND:    o = i_a & i_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:    o = shift_y;
      ALU_PASS_B: o = i_b;
`ifdef COTM32_ALU_MUL_EN
      ALU_MUL:    o = product[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  o = product[2*XLEN-1:XLEN];
`endif
      default:    o = '0;
    endcase
  end

  assign o_zero = (o == '0);

  // Reset takes priority over capture; its value matches a zero result.
  always_ff @(posedge i_clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (i_rst) begin
      o_q      <= '0;
      o_zero_q <= 1'b1;
    end else begin
      o_q      <= o;
      o_zero_q <= o_zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// The driver applies one operation per clock (shortly after the rising
// edge) and pushes the expected result into a scoreboard queue. The monitor
// runs on the falling edge: it pops the current entry and checks o/o_zero,
// then checks o_q/o_zero_q against the entry popped one cycle earlier.
// Expected values are either literal constants or come from a reference
// model written with plain integer arithmetic.
// Honours COTM32_ALU_MUL_EN to match the DUT build.
// ---------------------------------------------------------------------------
module tb_alu;
  import cotm32_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_a   = '0;
  logic [31:0] i_b   = '0;
  alu_op_t     i_op  = ALU_ADD;
  logic [31:0] o;
  logic        o_zero;
  logic [31:0] o_q;
  logic        o_zero_q;

  alu dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_op     (i_op),
    .o        (o),
    .o_zero   (o_zero),
    .o_q      (o_q),
    .o_zero_q (o_zero_q)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic        rst;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: the ALU's rules expressed with ordinary operators.
  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    longint      ps;
    logic [63:0] pu;
    sh = 32'(b[4:0]);
    ps = 0;
    pu = '0;
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      4'b1111: return b;
`ifdef COTM32_ALU_MUL_EN
      4'b1001: begin
        pu = {32'b0, a} * {32'b0, b};
        return pu[31:0];
      end
      4'b1010: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        return ps[63:32];
      end
      4'b1011: begin
        ps = longint'($signed(a)) * longint'({32'b0, b});
        return ps[63:32];
      end
      4'b1100: begin
        pu = {32'b0, a} * {32'b0, b};
        return pu[63:32];
      end
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Drive one operation just after a rising edge and queue its expectation.
  task automatic issue(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic rst);
    txn_t t;
    @(posedge i_clk);
    #2;
    i_op  = alu_op_t'(op);
    i_a   = a;
    i_b   = b;
    i_rst = rst;
    t.name = name;
    t.exp  = exp;
    t.rst  = rst;
    sb.push_back(t);
  endtask

  // Monitor: combinational check on the current entry, registered check on
  // the previous one (captured at the rising edge just before this sample).
  initial begin
    txn_t cur;
    txn_t prev;
    bit   have_prev;
    have_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (have_prev) begin
        check({prev.name, "/o_q"}, o_q, prev.rst ? 32'd0 : prev.exp);
        check({prev.name, "/o_zero_q"}, 32'(o_zero_q),
              (prev.rst || prev.exp == 32'd0) ? 32'd1 : 32'd0);
      end
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        check({cur.name, "/o"}, o, cur.exp);
        check({cur.name, "/o_zero"}, 32'(o_zero), (cur.exp == 32'd0) ? 32'd1 : 32'd0);
        prev      = cur;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] edge_vals [6];
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'h7FFF_FFFF;
    edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'hFFFF_FFFF;
    edge_vals[5] = 32'h0000_001F;

    // Reset state, then the registered path and reset dominance.
    issue("reset",     4'b0000, 32'd0, 32'd0, 32'd0, 1'b1);
    issue("add_reg",   4'b0000, 32'd1, 32'd2, 32'd3, 1'b0);
    issue("rst_dom",   4'b0000, 32'd1, 32'd2, 32'd3, 1'b1);
    issue("post_rst",  4'b0000, 32'd1, 32'd2, 32'd3, 1'b0);

    // Directed cases with literal expectations.
    issue("add_1_2",   4'b0000, 32'd1,         32'd2,         32'd3,         1'b0);
    issue("sub_8_3",   4'b1000, 32'd8,         32'd3,         32'd5,         1'b0);
    issue("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    issue("sub_wrap",  4'b1000, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);
    issue("or",        4'b0110, 32'h68,        32'h55,        32'h7D,        1'b0);
    issue("and",       4'b0111, 32'h68,        32'h55,        32'h40,        1'b0);
    issue("xor",       4'b0100, 32'h68,        32'h55,        32'h3D,        1'b0);
    issue("slt_neg",   4'b0010, -32'sd30,      32'd25,        32'd1,         1'b0);
    issue("sltu_neg",  4'b0011, -32'sd30,      32'd25,        32'd0,         1'b0);
    issue("slt_eq",    4'b0010, 32'd7,         32'd7,         32'd0,         1'b0);
    issue("sll_30_2",  4'b0001, 32'd30,        32'd2,         32'd120,       1'b0);
    issue("srl_8",     4'b0101, 32'hFFFF_FFFF, 32'd8,         32'h00FF_FFFF, 1'b0);
    issue("sra_m60_2", 4'b1101, -32'sd60,      32'd2,         32'hFFFF_FFF1, 1'b0);
    issue("sll_b21",   4'b0001, 32'd5,         32'h21,        32'd10,        1'b0);
    issue("sra_zero",  4'b1101, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001, 1'b0);
    issue("sra_31",    4'b1101, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0);
    issue("pass_b",    4'b1111, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0);
    issue("op_1110",   4'b1110, 32'h1234_5678, 32'h1111_1111, 32'd0,         1'b0);
`ifdef COTM32_ALU_MUL_EN
    issue("mul_7_m3",  4'b1001, 32'd7,         -32'sd3,       32'hFFFF_FFEB, 1'b0);
    issue("mulhu",     4'b1100, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0);
    issue("mulh_m1",   4'b1010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
    issue("mulhsu",    4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
    issue("mul_off",   4'b1001, 32'd7,         32'd3,         32'd0,         1'b0);
    issue("mulhu_off", 4'b1100, 32'hFFFF_FFFF, 32'd2,         32'd0,         1'b0);
`endif

    // Randomized operations across all 16 codes, mixing in edge operands.
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      issue($sformatf("rand%0d_op%0h", i, op), op, a, b, model(op, a, b),
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    // Let the monitor drain the queue, bounded in cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge i_clk);
    end
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge i_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
